// File: rtl/dm_store_buffer_if.sv
// Datapath-side memory-access bundle for dm_store_buffer.
//   cpu_addr  : word address (byte address bits 11:2)
//   cpu_wdata : store data
//   cpu_we    : store request
//   cpu_re    : load request
//   cpu_rdata : load result (forwarded or from dm)
//   stall     : store not accepted this cycle
// master = datapath, slave = store buffer.
interface dm_store_buffer_if #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 32
);
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_we;
  logic          cpu_re;
  logic [DW-1:0] cpu_rdata;
  logic          stall;

  modport master (
    output cpu_addr, cpu_wdata, cpu_we, cpu_re,
    input  cpu_rdata, stall
  );

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_we, cpu_re,
    output cpu_rdata, stall
  );
endinterface

// File: rtl/dm_store_buffer.sv
// Posted-write store buffer in front of the dm data memory.
// Stores are queued in a DEPTH-entry FIFO and drained one word per cycle
// whenever the dm port is not claimed by a load. Loads go to dm in the same
// cycle and are forwarded from the youngest matching buffered store.
// Ports:
//   clk         : system clock, rising edge
//   reset       : asynchronous active-low reset
//   cpu         : datapath bundle (slave side)
//   dm_addr     : dm word address
//   dm_data_in  : dm write data
//   dm_MemWrite : dm write enable
//   dm_MemRead  : dm read enable
//   dm_data_out : dm read data (combinational)
//   count       : occupied entries
//   empty       : count == 0
module dm_store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 10,
  parameter int unsigned DW    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  dm_store_buffer_if.slave       cpu,
  output logic [AW-1:0]          dm_addr,
  output logic [DW-1:0]          dm_data_in,
  output logic                   dm_MemWrite,
  output logic                   dm_MemRead,
  input  logic [DW-1:0]          dm_data_out,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] ent_addr [DEPTH];
  logic [DW-1:0] ent_data [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  logic          full;
  logic          enq;
  logic          drain;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic [PW-1:0] idx;

  assign full  = (count == CW'(DEPTH));
  // No bypass: a slot freed by this cycle's drain is not usable until next cycle.
  assign enq   = reset & cpu.cpu_we & ~full;
  assign drain = reset & ~cpu.cpu_re & (count != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq)   wr_ptr <= wr_ptr + PW'(1);
      if (drain) rd_ptr <= rd_ptr + PW'(1);
      case ({enq, drain})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage is intentionally not reset; pointers/count define validity.
  always_ff @(posedge clk) begin
    if (enq) begin
      ent_addr[wr_ptr] <= cpu.cpu_addr;
      ent_data[wr_ptr] <= cpu.cpu_wdata;
    end
  end

  // Walk oldest to youngest from rd_ptr; a later hit overrides an earlier
  // one, so the surviving value is the youngest match, wrap included.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if ((i < 32'(count)) && (ent_addr[idx] == cpu.cpu_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_data[idx];
      end
    end
  end

  always_comb begin
    cpu.stall     = 1'b0;
    cpu.cpu_rdata = '0;
    dm_MemWrite   = 1'b0;
    dm_MemRead    = 1'b0;
    dm_addr       = '0;
    dm_data_in    = '0;
    empty         = 1'b1;
    if (reset) begin
      cpu.stall = cpu.cpu_we & full;
      empty     = (count == '0);
      if (cpu.cpu_re) begin
        dm_MemRead    = 1'b1;
        dm_addr       = cpu.cpu_addr;
        cpu.cpu_rdata = fwd_hit ? fwd_data : dm_data_out;
      end else if (drain) begin
        dm_MemWrite = 1'b1;
        dm_addr     = ent_addr[rd_ptr];
        dm_data_in  = ent_data[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_dm_store_buffer.sv
module tb_dm_store_buffer;
  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic [9:0]  dm_addr;
  logic [31:0] dm_data_in;
  logic        dm_MemWrite;
  logic        dm_MemRead;
  logic [31:0] dm_data_out;
  logic [2:0]  count;
  logic        empty;

  dm_store_buffer_if #(.AW(10), .DW(32)) cpu_if ();

  dm_store_buffer #(.DEPTH(DEPTH), .AW(10), .DW(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu         (cpu_if.slave),
    .dm_addr     (dm_addr),
    .dm_data_in  (dm_data_in),
    .dm_MemWrite (dm_MemWrite),
    .dm_MemRead  (dm_MemRead),
    .dm_data_out (dm_data_out),
    .count       (count),
    .empty       (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment dm memory, written only by the DUT's dm port.
  logic [31:0] dm_mem [1024];
  assign dm_data_out = dm_mem[dm_addr];
  always @(posedge clk) if (dm_MemWrite) dm_mem[dm_addr] <= dm_data_in;

  // Reference model: program-ordered queue of pending stores plus the
  // memory image dm should hold once those stores have landed.
  typedef struct { logic [9:0] a; logic [31:0] d; } st_t;
  st_t         q[$];
  logic [31:0] ref_mem [1024];
  bit          m_full;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge reset) q.delete();

  always @(posedge clk) begin
    if (reset) begin
      m_full = (q.size() == DEPTH);
      if (!cpu_if.cpu_re && q.size() > 0) begin
        ref_mem[q[0].a] = q[0].d;
        void'(q.pop_front());
      end
      if (cpu_if.cpu_we && !m_full) q.push_back('{cpu_if.cpu_addr, cpu_if.cpu_wdata});
    end
  end

  // Cycle compare against the model.
  always @(negedge clk) begin
    logic [31:0] e_rd;
    logic [9:0]  e_addr;
    logic [31:0] e_din;
    logic        e_we, e_re, e_stall, hit;
    e_rd = '0; e_addr = '0; e_din = '0; e_we = 0; e_re = 0; e_stall = 0; hit = 0;
    if (reset) begin
      e_stall = cpu_if.cpu_we && (q.size() == DEPTH);
      if (cpu_if.cpu_re) begin
        e_re   = 1;
        e_addr = cpu_if.cpu_addr;
        e_rd   = ref_mem[cpu_if.cpu_addr];
        for (int i = q.size() - 1; i >= 0; i--)
          if (!hit && q[i].a == cpu_if.cpu_addr) begin hit = 1; e_rd = q[i].d; end
      end else if (q.size() > 0) begin
        e_we = 1; e_addr = q[0].a; e_din = q[0].d;
      end
    end
    check("m_stall",     {63'd0, cpu_if.stall}, {63'd0, e_stall});
    check("m_memwrite",  {63'd0, dm_MemWrite},  {63'd0, e_we});
    check("m_memread",   {63'd0, dm_MemRead},   {63'd0, e_re});
    check("m_dm_addr",   {54'd0, dm_addr},      {54'd0, e_addr});
    check("m_dm_din",    {32'd0, dm_data_in},   {32'd0, e_din});
    check("m_rdata",     {32'd0, cpu_if.cpu_rdata}, {32'd0, e_rd});
    check("m_count",     {61'd0, count},        64'(reset ? q.size() : 0));
    check("m_empty",     {63'd0, empty},        {63'd0, (!reset || q.size() == 0)});
  end

  task automatic set_in(input logic we, input logic re, input logic [9:0] a, input logic [31:0] d);
    cpu_if.cpu_we = we; cpu_if.cpu_re = re; cpu_if.cpu_addr = a; cpu_if.cpu_wdata = d;
  endtask
  task automatic tick; @(posedge clk); #1; endtask
  task automatic mid;  @(negedge clk); endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      dm_mem[i]  = 32'hC000_0000 + 32'(i);
      ref_mem[i] = 32'hC000_0000 + 32'(i);
    end
    dm_mem[7] = 32'h1234; ref_mem[7] = 32'h1234;
    reset = 1'b0;
    set_in(0, 0, 0, 0);
    mid;
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_memwrite", 64'(dm_MemWrite), 64'd0);
    @(posedge clk); #1 reset = 1'b1;

    // 1: single store, drain, read back via dm
    set_in(1, 0, 0, 16); mid;
    check("t1_pre_count", 64'(count), 64'd0); tick;
    set_in(0, 0, 0, 0); mid;
    check("t1_count", 64'(count), 64'd1);
    check("t1_memwrite", 64'(dm_MemWrite), 64'd1);
    check("t1_dm_addr", 64'(dm_addr), 64'd0);
    check("t1_dm_din", 64'(dm_data_in), 64'd16); tick;
    set_in(0, 1, 0, 0); mid;
    check("t1_empty", 64'(empty), 64'd1);
    check("t1_rdata", 64'(cpu_if.cpu_rdata), 64'd16); tick;

    // 2: forwarding while loads hold the port
    set_in(0, 1, 3, 0); mid; tick;
    set_in(1, 1, 10'h10, 32'hAAAA); mid;
    check("t2_same_cycle", 64'(cpu_if.cpu_rdata), 64'hC000_0010); tick;
    set_in(0, 1, 10'h10, 0); mid;
    check("t2_fwd", 64'(cpu_if.cpu_rdata), 64'hAAAA);
    check("t2_memread", 64'(dm_MemRead), 64'd1);
    check("t2_memwrite", 64'(dm_MemWrite), 64'd0);
    check("t2_count", 64'(count), 64'd1); tick;

    // 3: youngest match wins, drains in program order
    set_in(1, 1, 5, 1); mid; tick;
    set_in(1, 1, 5, 2); mid; tick;
    set_in(0, 1, 5, 0); mid;
    check("t3_fwd", 64'(cpu_if.cpu_rdata), 64'd2);
    check("t3_count", 64'(count), 64'd3); tick;
    set_in(0, 0, 0, 0); mid;
    check("t3_d0", 64'(dm_addr), 64'h10); tick; mid;
    check("t3_d1", {dm_addr, dm_data_in}, {10'd5, 32'd1}); tick; mid;
    check("t3_d2", {dm_addr, dm_data_in}, {10'd5, 32'd2}); tick; mid;
    check("t3_empty", 64'(empty), 64'd1); tick;

    // 4: fill, stall, release
    for (int i = 1; i <= 5; i++) begin
      set_in(1, 1, 10'(i), 32'(100 + i)); mid;
      check("t4_stall", 64'(cpu_if.stall), (i == 5) ? 64'd1 : 64'd0);
      if (i == 5) check("t4_full_count", 64'(count), 64'd4);
      tick;
    end
    set_in(1, 0, 5, 105); mid;
    check("t4_stall_drain", 64'(cpu_if.stall), 64'd1);
    check("t4_d1", 64'(dm_addr), 64'd1); tick;
    mid;
    check("t4_stall_clear", 64'(cpu_if.stall), 64'd0);
    check("t4_count3", 64'(count), 64'd3);
    check("t4_d2", 64'(dm_addr), 64'd2); tick;
    set_in(0, 0, 0, 0); mid;
    check("t4_count_hold", 64'(count), 64'd3); tick; mid;
    check("t4_d4", 64'(dm_addr), 64'd4); tick; mid;
    check("t4_d5", {dm_addr, dm_data_in}, {10'd5, 32'd105}); tick; mid;
    check("t4_empty", 64'(count), 64'd0); tick;

    // 5: asynchronous reset mid-drain
    for (int k = 0; k < 3; k++) begin
      set_in(1, 1, 10'(20 + k), 32'h500 + 32'(k)); mid; tick;
    end
    set_in(0, 0, 0, 0); mid;
    check("t5_drain20", {dm_MemWrite, dm_addr}, {1'b1, 10'd20}); tick; mid;
    check("t5_count2", 64'(count), 64'd2);
    #2 reset = 1'b0; #1;
    check("t5_async_we", 64'(dm_MemWrite), 64'd0);
    check("t5_async_count", 64'(count), 64'd0);
    check("t5_async_empty", 64'(empty), 64'd1);
    @(posedge clk); #1 reset = 1'b1; mid;
    check("t5_post_we", 64'(dm_MemWrite), 64'd0); tick;
    set_in(0, 1, 21, 0); mid;
    check("t5_stale21", 64'(cpu_if.cpu_rdata), 64'hC000_0015); tick;
    set_in(0, 1, 20, 0); mid;
    check("t5_landed20", 64'(cpu_if.cpu_rdata), 64'h500); tick;

    // 6: empty-buffer load, then wrap-around forwarding
    set_in(0, 1, 7, 0); mid;
    check("t6_dm_read", 64'(cpu_if.cpu_rdata), 64'h1234); tick;
    for (int i = 0; i < 10; i++) begin
      set_in(1, 0, 9, 32'h900 + 32'(i)); mid; tick;
    end
    set_in(0, 0, 0, 0); mid; tick; mid;
    check("t6_drained", 64'(count), 64'd0); tick;
    set_in(1, 1, 9, 32'hA); mid; tick;
    set_in(1, 1, 8, 32'hB); mid; tick;
    set_in(1, 1, 9, 32'hC); mid; tick;
    set_in(0, 1, 9, 0); mid;
    check("t6_wrap_fwd", 64'(cpu_if.cpu_rdata), 64'hC);
    check("t6_wrap_count", 64'(count), 64'd3); tick;
    set_in(1, 1, 9, 32'hD); mid; tick;
    set_in(0, 1, 9, 0); mid;
    check("t6_wrap_fwd2", 64'(cpu_if.cpu_rdata), 64'hD);
    check("t6_full", 64'(count), 64'd4); tick;
    set_in(0, 1, 8, 0); mid;
    check("t6_fwd8", 64'(cpu_if.cpu_rdata), 64'hB); tick;
    set_in(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick;
    set_in(0, 1, 9, 0); mid;
    check("t6_final_count", 64'(count), 64'd0);
    check("t6_final_dm", 64'(cpu_if.cpu_rdata), 64'hD); tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dm_store_buffer.md
Name: dm_store_buffer

Overview:
- Posted-write store buffer between the datapath's memory-access signals and the dm data memory.
- Stores are queued in a small FIFO and drained to dm one word per cycle whenever the dm port is not needed for a load.
- Loads are serviced from dm the same cycle, with youngest-match forwarding from pending buffered stores.
- Addressing is word-granular: addr[11:2], matching dm.

Parameters:
- DEPTH, 4: number of buffered stores; power of two, minimum 2.
- AW, 10: word-address width (byte address bits 11:2).
- DW, 32: data width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- cpu_addr  in  AW  word address from the datapath.
- cpu_wdata  in  DW  store data.
- cpu_we  in  1  store request (MemWrite from control).
- cpu_re  in  1  load request (MemRead from control).
- cpu_rdata  out  DW  load result.
- stall  out  1  store not accepted this cycle; the datapath holds the instruction.
- dm_addr  out  AW  dm address.
- dm_data_in  out  DW  dm write data.
- dm_MemWrite  out  1  dm write enable.
- dm_MemRead  out  1  dm read enable.
- dm_data_out  in  DW  dm read data; combinational, valid in the same cycle as dm_addr.
- count  out  $clog2(DEPTH)+1  number of occupied entries.
- empty  out  1  count == 0.

Behaviour:
- State:
  - DEPTH x {addr, data} entry array.
  - rd_ptr, wr_ptr, count.
  - full = (count == DEPTH).
- Reset (reset == 0, asynchronous):
  - rd_ptr = wr_ptr = count = 0.
  - Outputs forced while asserted: stall = 0, dm_MemWrite = 0, dm_MemRead = 0, dm_addr = 0, dm_data_in = 0, cpu_rdata = 0, empty = 1.
  - Entry contents are not cleared. Pending stores are discarded, including reset asserted mid-drain.
- Enqueue:
  - If cpu_we = 1 and !full: entry[wr_ptr] <= {cpu_addr, cpu_wdata}, wr_ptr++ (mod DEPTH) at the rising edge.
  - If cpu_we = 1 and full: stall = 1 combinationally and nothing is written.
  - stall = cpu_we & full. There is no same-cycle bypass when a drain frees a slot.
- Load port priority:
  - If cpu_re = 1: dm_MemRead = 1, dm_addr = cpu_addr, dm_MemWrite = 0. No drain this cycle.
- Drain:
  - Occurs when cpu_re = 0 and count > 0: dm_MemWrite = 1, dm_addr = entry[rd_ptr].addr, dm_data_in = entry[rd_ptr].data.
  - dm captures the write at the rising edge; rd_ptr++ (mod DEPTH) at the same edge.
  - Stores drain in program order. Stores to the same address are not merged.
- Idle (cpu_re = 0, count = 0): dm_MemWrite = 0, dm_MemRead = 0, dm_addr = 0, dm_data_in = 0.
- Forwarding:
  - cpu_rdata = data of the youngest valid entry whose addr == cpu_addr; if there is no match, cpu_rdata = dm_data_out.
  - Only entries present before this edge are searched. A store enqueued in the same cycle is not visible.
  - When cpu_re = 0, cpu_rdata = 0.
- Count update:
  - Enqueue and drain in the same cycle: count unchanged.
  - Enqueue only: count + 1.
  - Drain only: count - 1.
- Both cpu_we and cpu_re = 1: the load is serviced as above and the store is enqueued (if !full) at the edge.
- Pointer wrap-around: at DEPTH-1 both pointers wrap to 0. The youngest-match search is ordered from wr_ptr-1 back to rd_ptr across the wrap.
- Latency:
  - Store visible in dm 1 cycle after acceptance at the earliest.
  - Load data available combinationally in the same cycle.

Test Plan:
1. Release reset; cpu_we = 1, cpu_addr = 0, cpu_wdata = 16 for one cycle.
   -> count = 1. Next cycle dm_MemWrite = 1, dm_addr = 0, dm_data_in = 16. Following cycle count = 0, empty = 1; a load of address 0 returns 16 via dm.
2. Hold cpu_re = 1 on addr 3. Meanwhile store 0x10 <- 0xAAAA, then load 0x10.
   -> cpu_rdata = 0xAAAA (forwarded), dm_MemRead = 1, dm_MemWrite = 0, count = 1.
3. With cpu_re held, store 5 <- 1 then 5 <- 2; load 5.
   -> cpu_rdata = 2. After cpu_re drops, dm receives 5 <- 1 then 5 <- 2 in consecutive cycles.
4. With cpu_re held, issue 5 stores to addresses 1..5.
   -> The first 4 are accepted and count = 4. On the 5th, stall = 1 and count stays 4.
   -> Drop cpu_re: drains proceed to addresses 1, 2, 3, 4. Stall clears after the first drain and address 5 then enqueues.
5. Buffer holds 3 entries; assert reset = 0 mid-drain.
   -> Immediately (asynchronously) dm_MemWrite = 0 and count = 0. After release, no stale writes reach dm.
6. Buffer empty; load addr 7 with dm_data_out = 0x1234.
   -> cpu_rdata = 0x1234. A wrap-around case (10 store/drain cycles through DEPTH 4) forwards the correct youngest value.
